// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and defaults for the bit-serial adder sequencer.
// The sequencer's optional subtract mode is controlled by the SERIAL_ADD_SUB_EN macro.

package serial_add_pkg;

    // Default operand/result width in bits.
    localparam int unsigned SA_DEFAULT_WIDTH = 32'd8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage : serial_add_pkg

// File: rtl/sa_fa_cell.sv
// sa_fa_cell: purely combinational one-bit full adder.
// The sequencer feeds it one operand bit pair plus the registered carry each cycle.

module sa_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic prop_s;

    // Sum and carry of one bit position (propagate/generate form).
    always_comb begin
        prop_s = a_i ^ b_i;
        sum_o  = prop_s ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & prop_s);
    end

endmodule : sa_fa_cell

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: accepts two WIDTH-bit operands on a valid/ready handshake,
// adds them LSB-first through one full-adder cell (one bit per clock), and presents
// {cout, sum} on a valid/ready output handshake WIDTH cycles after acceptance.
// Optional feature: define SERIAL_ADD_SUB_EN to add the op_sub port (op_a - op_b,
// cout=1 meaning no borrow). Without it the block is an adder only.

module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter is just wide enough to reach WIDTH-1; it stops there instead of wrapping.
    localparam int unsigned     CNT_W    = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'd1);

    // Control state
    sa_state_e        state_q, state_d;
    logic             in_ready_q, out_valid_q;

    // Datapath state
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decoded control and cell connections
    logic             accept_s;
    logic             last_bit_s;
    logic             release_s;
    logic [WIDTH-1:0] load_b_s;
    logic             load_c_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    // Handshake decode, from registered state only apart from the qualifying input.
    always_comb begin
        accept_s   = (state_q == IDLE) && in_valid;
        last_bit_s = (cnt_q == CNT_LAST);
        release_s  = (state_q == DONE) && out_ready;
    end

`ifdef SERIAL_ADD_SUB_EN
    // Subtract loads ~op_b with a forced carry of 1 (two's complement negate).
    always_comb begin
        if (op_sub) begin
            load_b_s = ~op_b;
            load_c_s = 1'b1;
        end else begin
            load_b_s = op_b;
            load_c_s = cin;
        end
    end
`else
    // Addition only: operands and carry load as presented.
    always_comb begin
        load_b_s = op_b;
        load_c_s = cin;
    end
`endif

    sa_fa_cell u_fa_cell (
        .a_i    (shift_a_q[0]),
        .b_i    (shift_b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum_s),
        .cout_o (fa_cout_s)
    );

    // Next-state logic of the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // Return to IDLE only; acceptance needs a separate IDLE cycle.
                if (release_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Datapath next state: load on acceptance, shift one bit per RUN cycle, hold otherwise.
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shift_a_d = op_a;
                    shift_b_d = load_b_s;
                    sum_d     = {WIDTH{1'b0}};
                    carry_d   = load_c_s;
                    cnt_d     = {CNT_W{1'b0}};
                end else begin
                    // Result of the previous transaction stays visible.
                    sum_d     = sum_q;
                    carry_d   = carry_q;
                end
            end
            RUN: begin
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                sum_d     = {fa_sum_s, sum_q[WIDTH-1:1]};
                carry_d   = fa_cout_s;
                if (last_bit_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                // Result frozen until consumed.
                sum_d   = sum_q;
                carry_d = carry_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a_q <= {WIDTH{1'b0}};
            shift_b_q <= {WIDTH{1'b0}};
            sum_q     <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
        end
    end

    // After the last RUN edge the carry register holds the carry out of the MSB.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// Testbench for serial_add_sequencer (WIDTH=8): table-driven vectors plus hand-written
// backpressure, reset-mid-run, back-to-back and (with SERIAL_ADD_SUB_EN) subtract sequences.
// Results are checked against a scoreboard queue filled when stimulus is driven.

module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t         vecs [6];
    int           tests     = 0;
    int           fails     = 0;
    int           cyc       = 0;
    int           acc_count = 0;
    int           res_count = 0;
    int           acc_cyc   = 0;
    int           acc_hist [$];
    logic [W:0]   sb [$];
    logic         ov_prev   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    // cycle counter: value k after the k-th rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: acceptance tracking, latency and scoreboard compare, sampled on falling edge
    initial forever begin
        logic [W:0] e;
        @(negedge clk);
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc + 1;
                acc_hist.push_back(cyc + 1);
                acc_count++;
            end
            if (out_valid && !ov_prev) begin
                check("latency", cyc - acc_cyc, W);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", int'(sum), int'(e[W-1:0]));
                    check("cout", int'(cout), int'(e[W]));
                end
                res_count++;
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // drive one operand pair and return just after its acceptance edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec);
        int n = 0;
        op_a     = a;
        op_b     = b;
        cin      = c;
        in_valid = 1'b1;
        sb.push_back({ec, es});
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready %0b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        int n = 0;
        while (res_count < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (res_count < target) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d results expected %0d", res_count, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           target;
        int           base;
        int           n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   r;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, es: 8'h96, ec: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, es: 8'h00, ec: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, c: 1'b1, es: 8'h01, ec: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, es: 8'hFF, ec: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h7F, c: 1'b1, es: 8'h00, ec: 1'b1};
        vecs[5] = '{a: 8'h12, b: 8'h34, c: 1'b0, es: 8'h46, ec: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // table vectors
        for (int i = 0; i < 6; i++) begin
            target = res_count + 1;
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].es, vecs[i].ec);
            wait_res(target);
        end

        // random vectors against a reference sum
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            r  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            target = res_count + 1;
            send(ra, rb, rc, r[W-1:0], r[W]);
            wait_res(target);
        end

        // backpressure: result must hold while in_valid/operands toggle
        out_ready = 1'b0;
        target = res_count + 1;
        send(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid_rise", int'(out_valid), 1);
        base = acc_count;
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            op_a     = W'($urandom_range(0, 255));
            op_b     = W'($urandom_range(0, 255));
            cin      = ~cin;
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_sum", int'(sum), 32'h1E);
            check("bp_cout", int'(cout), 1);
            @(posedge clk); #1;
        end
        check("bp_no_accept", acc_count, base);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        check("idle_hold_sum", int'(sum), 32'h1E);
        check("idle_hold_cout", int'(cout), 1);
        wait_res(target);

        // reset three cycles into a run discards it
        send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_sum", int'(sum), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        target = res_count + 1;
        send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
        wait_res(target);

        // back-to-back with out_ready high and in_valid held
        out_ready = 1'b1;
        target    = res_count + 2;
        base      = acc_count;
        n         = acc_hist.size();
        op_a      = 8'h10;
        op_b      = 8'h20;
        cin       = 1'b0;
        in_valid  = 1'b1;
        sb.push_back({1'b0, 8'h30});
        for (int k = 0; k < 200 && acc_count < base + 1; k++) begin
            @(posedge clk); #1;
        end
        op_a = 8'h80;
        op_b = 8'h80;
        sb.push_back({1'b1, 8'h00});
        for (int k = 0; k < 200 && acc_count < base + 2; k++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_res(target);
        if (acc_hist.size() >= n + 2) begin
            check("b2b_gap", acc_hist[n+1] - acc_hist[n], W + 2);
        end else begin
            tests++;
            fails++;
            $display("FAIL b2b_accepts: got %0d acceptances expected 2", acc_hist.size() - n);
        end

`ifdef SERIAL_ADD_SUB_EN
        // subtract mode: carry register forced to 1, cin ignored
        op_sub = 1'b1;
        target = res_count + 1;
        send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        wait_res(target);
        target = res_count + 1;
        send(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        wait_res(target);
        op_sub = 1'b0;
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_add_sequencer
